// File: rtl/dma_burst_scheduler.sv
// rtl/dma_burst_scheduler.sv - splits one DMA copy into read/write bursts staged through a local FIFO
// Raises dma_irq when the whole copy has been written back.
module dma_burst_scheduler #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 4,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 16
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              dma_en,
  input  logic [ADDR_W-1:0] dma_src,
  input  logic [ADDR_W-1:0] dma_dst,
  input  logic [CNT_W-1:0]  dma_len,
  input  logic              dma_start,
  output logic              dma_busy,
  output logic              dma_irq,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [LEN_W-1:0]  rd_len,
  input  logic              rd_ack,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_last,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LEN_W-1:0]  wr_len,
  input  logic              wr_ack,
  output logic [DATA_W-1:0] wr_data,
  output logic [DATA_W/8-1:0] wr_strb,
  input  logic              wr_pop,
  input  logic              wr_done,
  input  logic              wr_err,
  output logic              dma_err
);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam int PTR_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_DATA, S_WR_REQ, S_WR_DATA, S_WR_RESP, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [ADDR_W-1:0] r_src, r_dst;
  logic [CNT_W-1:0]  r_rem;
  logic [BEAT_W-1:0] r_beats, r_pop_cnt, r_count, w_beats;
  logic              r_rd_req, r_wr_req, r_busy, r_irq, r_err;
  logic [DATA_W-1:0] r_mem [MAX_BURST];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic              w_full, w_empty, w_push, w_pop, w_start, w_rd_hs, w_wr_hs, w_last_pop;

  assign w_beats    = (r_rem > CNT_W'(MAX_BURST)) ? BEAT_W'(MAX_BURST) : BEAT_W'(r_rem);
  assign w_start    = dma_start && dma_en && (r_state == S_IDLE);
  assign w_rd_hs    = r_rd_req && rd_ack;
  assign w_wr_hs    = r_wr_req && wr_ack;
  assign w_full     = (r_count == BEAT_W'(MAX_BURST));
  assign w_empty    = (r_count == '0);
  assign w_push     = (r_state == S_RD_DATA) && rd_valid && !w_full;
  assign w_pop      = wr_pop && !w_empty;
  // Completion counts the write master's pops, so a short read burst cannot stall the FSM.
  assign w_last_pop = (r_state == S_WR_DATA) && wr_pop && ((r_pop_cnt + 1'b1) == r_beats);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_next = (dma_len == '0) ? S_DONE : S_RD_REQ;
      S_RD_REQ:  if (w_rd_hs) w_next = S_RD_DATA;
      S_RD_DATA: if (rd_valid && rd_last) w_next = S_WR_REQ;
      S_WR_REQ:  if (w_wr_hs) w_next = S_WR_DATA;
      S_WR_DATA: if (w_last_pop) w_next = S_WR_RESP;
      S_WR_RESP: if (wr_done) w_next = (r_rem == CNT_W'(r_beats)) ? S_DONE : S_RD_REQ;
      S_DONE:    if (!dma_en) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESETn) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_rem     <= '0;
      r_beats   <= '0;
      r_pop_cnt <= '0;
      r_rd_req  <= 1'b0;
      r_wr_req  <= 1'b0;
      r_busy    <= 1'b0;
      r_irq     <= 1'b0;
      r_err     <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
    end else begin
      r_state  <= w_next;
      r_busy   <= (w_next != S_IDLE) && (w_next != S_DONE);
      r_rd_req <= (r_state == S_RD_REQ) && !w_rd_hs;
      r_wr_req <= (r_state == S_WR_REQ) && !w_wr_hs;
      if (r_state == S_RD_REQ) r_beats <= w_beats;
      if (w_start) begin
        r_src <= dma_src;
        r_dst <= dma_dst;
        r_rem <= dma_len;
      end else if ((r_state == S_WR_RESP) && wr_done) begin
        r_src <= r_src + (ADDR_W'(r_beats) << 2);
        r_dst <= r_dst + (ADDR_W'(r_beats) << 2);
        r_rem <= r_rem - CNT_W'(r_beats);
      end
      if (r_state == S_WR_REQ) r_pop_cnt <= '0;
      else if ((r_state == S_WR_DATA) && wr_pop) r_pop_cnt <= r_pop_cnt + 1'b1;
      if ((w_next == S_DONE) && (r_state != S_DONE)) r_irq <= 1'b1;
      else if (!dma_en) r_irq <= 1'b0;
      if (w_start) r_err <= 1'b0;
      else if (wr_done && wr_err) r_err <= 1'b1;
      if (w_push) r_wptr <= (r_wptr == PTR_W'(MAX_BURST - 1)) ? '0 : r_wptr + 1'b1;
      if (w_pop) r_rptr <= (r_rptr == PTR_W'(MAX_BURST - 1)) ? '0 : r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_push) r_mem[r_wptr] <= rd_data;
  end

  assign dma_busy = r_busy;
  assign dma_irq  = r_irq;
  assign dma_err  = r_err;
  assign rd_req   = r_rd_req;
  assign rd_addr  = r_rd_req ? r_src : '0;
  assign rd_len   = r_rd_req ? LEN_W'(r_beats - 1'b1) : '0;
  assign wr_req   = r_wr_req;
  assign wr_addr  = r_wr_req ? r_dst : '0;
  assign wr_len   = r_wr_req ? LEN_W'(r_beats - 1'b1) : '0;
  assign wr_data  = w_empty ? '0 : r_mem[r_rptr];
  assign wr_strb  = '1;

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge ACLK) disable iff (ARESETn)
    !((r_state == S_RD_DATA) && rd_valid && w_full));
  a_no_underflow: assert property (@(posedge ACLK) disable iff (ARESETn)
    !(wr_pop && w_empty));
`endif
endmodule

// File: tb/tb_dma_burst_scheduler.sv
// tb/tb_dma_burst_scheduler.sv - scoreboard bench for dma_burst_scheduler
// Randomised master models; expectations come from a burst-list reference model.
module tb_dma_burst_scheduler;
  localparam int MB = 16;

  logic        ACLK, ARESETn, dma_en, dma_start;
  logic [31:0] dma_src, dma_dst;
  logic [15:0] dma_len;
  logic        dma_busy, dma_irq, dma_err;
  logic        rd_req, rd_ack, rd_valid, rd_last;
  logic [31:0] rd_addr, rd_data;
  logic [3:0]  rd_len, wr_len;
  logic        wr_req, wr_ack, wr_pop, wr_done, wr_err;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;

  dma_burst_scheduler dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .dma_en(dma_en), .dma_src(dma_src), .dma_dst(dma_dst),
    .dma_len(dma_len), .dma_start(dma_start), .dma_busy(dma_busy), .dma_irq(dma_irq),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_last(rd_last), .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len),
    .wr_ack(wr_ack), .wr_data(wr_data), .wr_strb(wr_strb), .wr_pop(wr_pop), .wr_done(wr_done),
    .wr_err(wr_err), .dma_err(dma_err)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  typedef struct packed { logic [31:0] addr; logic [3:0] len; } req_t;
  req_t        exp_rd[$], exp_wr[$];
  logic [31:0] exp_data[$];
  int          exp_irq;
  logic        exp_err;
  int          n_checks, n_fails;
  int          ack_delay;
  logic        pop_gaps, inject_err;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference: a copy is a list of bursts of min(remaining, MB) words, data in source order.
  function automatic void model_copy(logic [31:0] s, logic [31:0] d, int len);
    req_t r;
    for (int off = 0; off < len; off += MB) begin
      int b = (len - off < MB) ? len - off : MB;
      r.len  = 4'(b - 1);
      r.addr = s + 32'(off * 4);
      exp_rd.push_back(r);
      r.addr = d + 32'(off * 4);
      exp_wr.push_back(r);
    end
    for (int i = 0; i < len; i++) exp_data.push_back(mem_word(s + 32'(i * 4)));
    exp_irq++;
  endfunction

  // Read master
  initial begin
    int ph, dly, idx, beats;
    logic [31:0] base;
    rd_ack = 0; rd_valid = 0; rd_last = 0; rd_data = 0; ph = 0; dly = 0; idx = 0; beats = 0; base = 0;
    forever begin
      @(posedge ACLK); #1;
      rd_ack = 0; rd_valid = 0; rd_last = 0;
      if (ARESETn) ph = 0;
      else begin
        if (ph == 0 && rd_req) begin
          dly = (ack_delay >= 0) ? ack_delay : int'($urandom_range(0, 3));
          ph = 1;
        end
        if (ph == 1) begin
          if (dly == 0) begin
            rd_ack = 1; base = rd_addr; beats = int'(rd_len) + 1; idx = 0; ph = 2;
          end else dly--;
        end else if (ph == 2 && $urandom_range(0, 3) != 0) begin
          rd_valid = 1;
          rd_data  = mem_word(base + 32'(idx * 4));
          rd_last  = (idx == beats - 1);
          idx++;
          if (rd_last) ph = 0;
        end
      end
    end
  end

  // Write master
  initial begin
    int ph, dly, cnt, beats;
    wr_ack = 0; wr_pop = 0; wr_done = 0; wr_err = 0; ph = 0; dly = 0; cnt = 0; beats = 0;
    forever begin
      @(posedge ACLK); #1;
      wr_ack = 0; wr_pop = 0; wr_done = 0; wr_err = 0;
      if (ARESETn) ph = 0;
      else begin
        if (ph == 0 && wr_req) begin
          dly = (ack_delay >= 0) ? ack_delay : int'($urandom_range(0, 3));
          ph = 1;
        end
        if (ph == 1) begin
          if (dly == 0) begin
            wr_ack = 1; beats = int'(wr_len) + 1; cnt = 0; ph = 2;
          end else dly--;
        end else if (ph == 2) begin
          if (!pop_gaps || $urandom_range(0, 2) != 0) begin
            wr_pop = 1; cnt++;
            if (cnt == beats) begin ph = 3; dly = int'($urandom_range(0, 2)); end
          end
        end else if (ph == 3) begin
          if (dly == 0) begin
            wr_done = 1; wr_err = inject_err; inject_err = 0; ph = 0;
          end else dly--;
        end
      end
    end
  end

  // Monitor: checks every handshake against the scoreboard queues
  initial begin
    logic prev_irq;
    prev_irq = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        if (rd_req) begin
          chk("rd_req_expected", exp_rd.size() > 0, 1);
          if (exp_rd.size() > 0) begin
            chk("rd_addr", rd_addr, exp_rd[0].addr);
            chk("rd_len", rd_len, exp_rd[0].len);
            if (rd_ack) void'(exp_rd.pop_front());
          end
        end
        if (wr_req) begin
          chk("wr_req_expected", exp_wr.size() > 0, 1);
          if (exp_wr.size() > 0) begin
            chk("wr_addr", wr_addr, exp_wr[0].addr);
            chk("wr_len", wr_len, exp_wr[0].len);
            if (wr_ack) void'(exp_wr.pop_front());
          end
        end
        if (wr_pop) begin
          chk("wr_data_expected", exp_data.size() > 0, 1);
          if (exp_data.size() > 0) chk("wr_data", wr_data, exp_data.pop_front());
          chk("wr_strb", wr_strb, 4'hF);
        end
        if (dma_irq && !prev_irq) begin
          chk("irq_expected", exp_irq > 0, 1);
          if (exp_irq > 0) begin
            exp_irq--;
            chk("irq_queues_drained", exp_rd.size() + exp_wr.size() + exp_data.size(), 0);
            chk("err_at_irq", dma_err, exp_err);
          end
        end
        prev_irq = dma_irq;
      end else prev_irq = 0;
    end
  end

  task automatic start_copy(logic [31:0] s, logic [31:0] d, int len, logic inj);
    model_copy(s, d, len);
    exp_err = inj;
    dma_src = s; dma_dst = d; dma_len = 16'(len);
    @(posedge ACLK); #1;
    dma_start = 1; inject_err = inj;
    @(posedge ACLK); #1;
    dma_start = 0;
    @(negedge ACLK);
    chk("err_cleared_on_start", dma_err, 0);
    chk("busy_after_start", dma_busy, len != 0);
  endtask

  task automatic do_copy(logic [31:0] s, logic [31:0] d, int len, logic inj, output int cyc);
    start_copy(s, d, len, inj);
    cyc = 0;
    while (!dma_irq && cyc < 4000) begin
      @(negedge ACLK);
      cyc++;
    end
    chk("irq_timeout", dma_irq, 1);
    @(negedge ACLK);
    chk("busy_at_done", dma_busy, 0);
    chk("irq_count", exp_irq, 0);
    chk("err_sticky", dma_err, inj);
    @(posedge ACLK); #1; dma_en = 0;
    @(posedge ACLK); #1; dma_en = 1;
    @(negedge ACLK);
    chk("irq_cleared", dma_irq, 0);
    chk("err_after_irq_clear", dma_err, inj);
  endtask

  task automatic check_idle_outputs(string tag);
    chk({tag, "_rd_req"}, rd_req, 0);
    chk({tag, "_wr_req"}, wr_req, 0);
    chk({tag, "_busy"}, dma_busy, 0);
    chk({tag, "_irq"}, dma_irq, 0);
    chk({tag, "_err"}, dma_err, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_rd_len"}, rd_len, 0);
    chk({tag, "_wr_len"}, wr_len, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
  endtask

  initial begin
    #500000;
    n_fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    int cyc, waited;
    n_checks = 0; n_fails = 0; exp_irq = 0; exp_err = 0;
    ack_delay = -1; pop_gaps = 0; inject_err = 0;
    ARESETn = 1; dma_en = 1; dma_start = 0; dma_src = 0; dma_dst = 0; dma_len = 0;
    repeat (3) @(posedge ACLK);
    #2 ARESETn = 0;
    @(negedge ACLK);
    check_idle_outputs("reset");

    do_copy(32'h1000, 32'h2000, 8, 0, cyc);
    do_copy(32'h1000, 32'h2000, 40, 0, cyc);

    do_copy(32'h1000, 32'h2000, 0, 0, cyc);
    chk("len0_done_latency_ok", cyc <= 2, 1);

    ack_delay = 5; pop_gaps = 1;
    do_copy(32'h3000, 32'h8000, 37, 0, cyc);
    ack_delay = -1;

    do_copy(32'h5000, 32'h6000, 32, 1, cyc);
    do_copy(32'h5100, 32'h6100, 5, 0, cyc);

    // Reset while the write master is draining the FIFO
    start_copy(32'h4000, 32'h9000, 16, 0);
    waited = 0;
    while (!wr_pop && waited < 2000) begin
      @(negedge ACLK);
      waited++;
    end
    chk("reached_wr_data", wr_pop, 1);
    @(posedge ACLK); #2 ARESETn = 1;
    exp_rd.delete(); exp_wr.delete(); exp_data.delete(); exp_irq = 0; exp_err = 0;
    @(posedge ACLK); #2 ARESETn = 0;
    @(negedge ACLK);
    check_idle_outputs("midreset");
    do_copy(32'h4000, 32'h9000, 16, 0, cyc);

    for (int k = 0; k < 5; k++) begin
      pop_gaps = $urandom_range(0, 1) == 1;
      do_copy(32'($urandom_range(0, 16'hFFFF)) << 2, 32'($urandom_range(0, 16'hFFFF)) << 2,
              int'($urandom_range(1, 50)), 1'($urandom_range(0, 1)), cyc);
    end

    chk("final_rd_queue", exp_rd.size(), 0);
    chk("final_wr_queue", exp_wr.size(), 0);
    chk("final_data_queue", exp_data.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
